// File: rtl/matrix_mem_ctrl.sv
// Memory stage for the coprocessor: owns a byte RAM and serves single-byte
// read/write plus whole-matrix load/store over the wide matrix buses.
module matrix_mem_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int MAT_N  = 25
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      wr,
   input  logic                      mat,
   input  logic [ADDR_W-1:0]         address,
   input  logic [DATA_W-1:0]         data_in,
   input  logic [MAT_N*DATA_W-1:0]   matrix_in,
   output logic [DATA_W-1:0]         data_out,
   output logic [MAT_N*DATA_W-1:0]   matrix_out,
   output logic                      busy,
   output logic                      done
);

   localparam int MW    = MAT_N * DATA_W;
   localparam int CNT_W = $clog2(MAT_N + 1);

   typedef enum logic [2:0] {IDLE, BYTE_RD, BYTE_WR, MAT_LD, MAT_ST, DONE} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   base;
   logic [MW-1:0]       st_reg;
   logic [MW-1:0]       asm_reg;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   mem [2**ADDR_W];
   logic [ADDR_W-1:0]   ram_addr;
   logic                ram_we;

   // Element offset wraps naturally in the ADDR_W-bit adder.
   assign ram_addr = base + ADDR_W'(cnt);
   assign ram_we   = !reset && ((state == BYTE_WR) || (state == MAT_ST));

   // RAM is never reset; reads are registered and issued every cycle.
   always_ff @(posedge clk) begin
      if (ram_we)
         mem[ram_addr] <= st_reg[DATA_W-1:0];
      rd_data <= mem[ram_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         data_out   <= '0;
         matrix_out <= '0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base   <= address;
                  st_reg <= mat ? matrix_in : MW'(data_in);
                  cnt    <= '0;
                  busy   <= 1'b1;
                  if (mat)
                     state <= wr ? MAT_ST : MAT_LD;
                  else
                     state <= wr ? BYTE_WR : BYTE_RD;
               end
            end
            BYTE_WR: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end
            BYTE_RD: begin
               if (cnt == '0) begin
                  cnt <= CNT_W'(1);
               end else begin
                  data_out <= rd_data;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            MAT_ST: begin
               st_reg <= st_reg >> DATA_W;
               if (cnt == CNT_W'(MAT_N - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            // Read data trails the address by one cycle, so element k lands while k+1 is read.
            MAT_LD: begin
               if (cnt == CNT_W'(MAT_N)) begin
                  matrix_out <= {rd_data, asm_reg[MW-1:DATA_W]};
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt != '0)
                     asm_reg <= {rd_data, asm_reg[MW-1:DATA_W]};
               end
            end
            DONE: begin
               if (!start) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// Randomized and directed bench for matrix_mem_ctrl, checked each cycle against
// a command-level reference model holding its own copy of the RAM.
module tb_matrix_mem_ctrl;

   logic          clk = 1'b0;
   logic          reset, start, wr, mat;
   logic [7:0]    address, data_in;
   logic [199:0]  matrix_in;
   logic [7:0]    data_out;
   logic [199:0]  matrix_out;
   logic          busy, done;

   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;

   matrix_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .MAT_N(25)) dut (
      .clk(clk), .reset(reset), .start(start), .wr(wr), .mat(mat),
      .address(address), .data_in(data_in), .matrix_in(matrix_in),
      .data_out(data_out), .matrix_out(matrix_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic int lat_of(input logic w, input logic m);
      return w ? (m ? 25 : 1) : (m ? 26 : 2);
   endfunction

   function automatic logic [199:0] rand_mat();
      logic [199:0] v;
      for (int i = 0; i < 25; i++) v[8*i +: 8] = 8'($urandom);
      return v;
   endfunction

   task automatic check_output(input string name, input logic [199:0] act, input logic [199:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a command completes a fixed number of edges after acceptance.
   logic [7:0]   ref_mem [256];
   logic         m_busy = 1'b0, m_done = 1'b0, m_inflight = 1'b0;
   logic [7:0]   m_data_out = '0;
   logic [199:0] m_mat_out = '0;
   logic         m_wr, m_mat;
   logic [7:0]   m_addr, m_din;
   logic [199:0] m_min;
   int           m_elapsed = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_inflight = 1'b0;
         m_data_out = '0; m_mat_out = '0;
      end else if (m_inflight) begin
         m_elapsed++;
         if (m_wr && m_elapsed <= (m_mat ? 25 : 1))
            ref_mem[(int'(m_addr) + m_elapsed - 1) % 256] =
               m_mat ? m_min[8*(m_elapsed-1) +: 8] : m_din;
         if (m_elapsed == lat_of(m_wr, m_mat)) begin
            if (!m_wr && m_mat)
               for (int i = 0; i < 25; i++) m_mat_out[8*i +: 8] = ref_mem[(int'(m_addr) + i) % 256];
            else if (!m_wr)
               m_data_out = ref_mem[m_addr];
            m_inflight = 1'b0; m_busy = 1'b0; m_done = 1'b1;
         end
      end else if (m_done) begin
         if (!start) m_done = 1'b0;
      end else if (start) begin
         m_wr = wr; m_mat = mat; m_addr = address; m_din = data_in; m_min = matrix_in;
         m_inflight = 1'b1; m_busy = 1'b1; m_elapsed = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_output("busy", busy, m_busy);
         check_output("done", done, m_done);
         check_output("data_out", data_out, m_data_out);
         check_output("matrix_out", matrix_out, m_mat_out);
      end
   end

   task automatic scramble_inputs();
      wr = 1'($urandom); mat = 1'($urandom);
      address = 8'($urandom); data_in = 8'($urandom); matrix_in = rand_mat();
   endtask

   task automatic apply_stimulus(input string name, input logic w, input logic m,
                                 input logic [7:0] a, input logic [7:0] d,
                                 input logic [199:0] mi, input int hold_extra);
      int lat;
      lat = 0;
      @(negedge clk);
      wr = w; mat = m; address = a; data_in = d; matrix_in = mi; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      scramble_inputs();
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      check_output({name, " done"}, done, 1'b1);
      check_output({name, " latency"}, lat, lat_of(w, m));
      for (int k = 0; k < hold_extra; k++) begin
         @(posedge clk);
         #1 check_output({name, " held"}, done, 1'b1);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1 check_output({name, " release"}, done, 1'b0);
   endtask

   logic [199:0] mseq, mr;

   initial begin
      reset = 1'b1; start = 1'b0; wr = 1'b0; mat = 1'b0;
      address = '0; data_in = '0; matrix_in = '0;
      for (int i = 0; i < 25; i++) mseq[8*i +: 8] = 8'(i + 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("reset busy", busy, 1'b0);
      check_output("reset done", done, 1'b0);
      check_output("reset data_out", data_out, 8'h00);
      check_output("reset matrix_out", matrix_out, 200'h0);
      reset = 1'b0;
      chk_en = 1'b1;

      for (int a = 0; a < 256; a++)
         apply_stimulus("fill", 1'b1, 1'b0, 8'(a), 8'($urandom), '0, 0);

      apply_stimulus("wr1", 1'b1, 1'b0, 8'h10, 8'h5A, '0, 0);
      apply_stimulus("rd1", 1'b0, 1'b0, 8'h10, 8'h00, '0, 0);
      check_output("rd1 value", data_out, 8'h5A);

      apply_stimulus("st2", 1'b1, 1'b1, 8'h20, 8'h00, mseq, 0);
      apply_stimulus("ld2", 1'b0, 1'b1, 8'h20, 8'h00, '0, 0);
      check_output("ld2 elem0", matrix_out[7:0], 8'h01);
      check_output("ld2 elem24", matrix_out[199:192], 8'h19);
      check_output("ld2 full", matrix_out, mseq);
      apply_stimulus("rd2", 1'b0, 1'b0, 8'h38, 8'h00, '0, 0);
      check_output("rd2 value", data_out, 8'h19);

      apply_stimulus("st3", 1'b1, 1'b1, 8'hF0, 8'h00, mseq, 0);
      apply_stimulus("rd3a", 1'b0, 1'b0, 8'h00, 8'h00, '0, 0);
      check_output("wrap 0x00", data_out, 8'h11);
      apply_stimulus("rd3b", 1'b0, 1'b0, 8'h08, 8'h00, '0, 0);
      check_output("wrap 0x08", data_out, 8'h19);

      apply_stimulus("wr4", 1'b1, 1'b0, 8'h80, 8'h77, '0, 5);
      apply_stimulus("rd4", 1'b0, 1'b0, 8'h80, 8'h00, '0, 0);
      check_output("rd4 value", data_out, 8'h77);

      // Abort a load at E+10; matrix_out must still show the earlier load just before.
      @(negedge clk);
      wr = 1'b0; mat = 1'b1; address = 8'h20; start = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      check_output("ld5 hold", matrix_out, mseq);
      reset = 1'b1; start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_output("abort busy", busy, 1'b0);
      check_output("abort done", done, 1'b0);
      check_output("abort matrix_out", matrix_out, 200'h0);
      apply_stimulus("rd5", 1'b0, 1'b0, 8'h20, 8'h00, '0, 0);
      check_output("rd5 value", data_out, 8'h01);

      // Abort a store at E+10: elements 0..8 committed, the rest untouched.
      @(negedge clk);
      wr = 1'b1; mat = 1'b1; address = 8'h60; matrix_in = mseq; start = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1; start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      apply_stimulus("ld5b", 1'b0, 1'b1, 8'h60, 8'h00, '0, 0);
      check_output("ld5b elem0", matrix_out[7:0], 8'h01);
      check_output("ld5b elem8", matrix_out[71:64], 8'h09);

      // Reset and start on the same edge: the write must be dropped.
      @(negedge clk);
      wr = 1'b1; mat = 1'b0; address = 8'h20; data_in = 8'hEE; start = 1'b1; reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check_output("rst+start busy", busy, 1'b0);
      apply_stimulus("rd5c", 1'b0, 1'b0, 8'h20, 8'h00, '0, 0);
      check_output("rd5c value", data_out, 8'h01);

      mr = rand_mat();
      apply_stimulus("st6", 1'b1, 1'b1, 8'h40, 8'h00, mr, 0);
      apply_stimulus("ld6", 1'b0, 1'b1, 8'h40, 8'h00, '0, 0);
      check_output("ld6 full", matrix_out, mr);

      for (int n = 0; n < 150; n++)
         apply_stimulus("rand", 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                        rand_mat(), int'($urandom_range(0, 2)));

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
